pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). Generalises the fixed-field pipeline register:
- one packed data vector and one packed control vector of configurable width
- valid/ready handshake with a 2-entry skid buffer, so stalls do not create a combinational ready path
- synchronous flush that inserts a bubble
- saturating back-pressure stall counter for performance monitoring

---
 rtl/pipe_stage_elastic.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// ----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline register for a boundary between two pipeline stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one packed data vector and one
// packed control vector, and it uses a valid/ready handshake. A second
// "skid" entry absorbs the beat that is already in flight when downstream
// stalls. Because of this, in_ready_o comes only from state flops and never
// from out_ready_i through combinational logic.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous flush; empties the stage and drives a bubble
//   in_valid_i   upstream beat present
//   in_ready_o   stage can accept (low only while both entries are full)
//   in_data_i    upstream data payload   [DATA_W]
//   in_ctrl_i    upstream control payload [CTRL_W]
//   out_valid_o  main entry holds a valid beat
//   out_ready_i  downstream accepts
//   out_data_o   main entry data          [DATA_W]
//   out_ctrl_o   main entry control       [CTRL_W]
//   stall_cnt_o  saturating count of cycles with out_valid_o=1, out_ready_i=0
// ----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic outValid;
    logic inReady;
    logic accept;
    logic consume;

    // Every storage element is reset, so no X can leak downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= BUBBLE_CTRL;
            skidData_q <= '0;
            skidCtrl_q <= BUBBLE_CTRL;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Next-state logic. Flush takes priority over every transfer. Any beat
    // accepted in the flush cycle is dropped. A beat consumed in the same
    // cycle has already been handed to downstream.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = BUSY;
                BUSY: begin
                    if (accept && !consume)      state_d = FULL;
                    else if (!accept && consume) state_d = EMPTY;
                end
                FULL: if (consume) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath next values. After a consume that leaves the stage empty, the
    // main entry keeps its old value. Only reset and flush load the bubble.
    always_comb begin
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        if (flush_i) begin
            mainData_d = '0;
            mainCtrl_d = BUBBLE_CTRL;
            skidData_d = '0;
            skidCtrl_d = BUBBLE_CTRL;
        end else begin
            case (state_q)
                EMPTY, BUSY: begin
                    if (accept && (state_q == EMPTY || consume)) begin
                        mainData_d = in_data_i;
                        mainCtrl_d = in_ctrl_i;
                    end else if (accept) begin
                        skidData_d = in_data_i;
                        skidCtrl_d = in_ctrl_i;
                    end
                end
                FULL: begin
                    if (consume) begin
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // The stall counter looks at the handshake before flush has any effect,
    // so a stalled flush cycle is still counted. It stops at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (outValid && !out_ready_i && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Outputs decode only registered state. This keeps out_ready_i off the
    // in_ready_o path.
    always_comb begin
        outValid = (state_q != EMPTY);
        inReady  = (state_q != FULL);
    end

    assign accept      = in_valid_i & inReady;
    assign consume     = outValid & out_ready_i;
    assign in_ready_o  = inReady;
    assign out_valid_o = outValid;
    assign out_data_o  = mainData_q;
    assign out_ctrl_o  = mainCtrl_q;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Directed testbench for pipe_stage_elastic with a narrow 4-bit stall counter
// and a non-zero bubble control value. A reference occupancy model with a
// scoreboard queue keeps the expected beats. Beats are pushed when the model
// accepts them and popped when downstream consumes them. The DUT outputs are
// compared to the model on every falling clock edge.
// ----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int          DATA_W = 32;
    localparam int          CTRL_W = 8;
    localparam int          CNT_W  = 4;
    localparam logic [7:0]  BUBBLE = 8'hA5;

    logic              clk;
    logic              rstN;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic [CTRL_W-1:0] inCtrl;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [CTRL_W-1:0] outCtrl;
    logic [CNT_W-1:0]  stallCnt;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard entries hold {data, ctrl}.
    logic [DATA_W+CTRL_W-1:0] sb[$];
    logic [DATA_W+CTRL_W-1:0] lastOut;
    logic [CNT_W-1:0]         modelCnt;

    pipe_stage_elastic #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .BUBBLE_CTRL(BUBBLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .flush_i    (flush),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .in_data_i  (inData),
        .in_ctrl_i  (inCtrl),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o (outData),
        .out_ctrl_o (outCtrl),
        .stall_cnt_o(stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reset the model to match the DUT's reset state.
    task automatic modelReset();
        sb.delete();
        lastOut  = {{DATA_W{1'b0}}, BUBBLE};
        modelCnt = '0;
    endtask

    // Call at a falling edge. The task drives one cycle of inputs, compares
    // the DUT against the model, advances the model across the next rising
    // edge, and returns at the following falling edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] d,
                                 input logic [7:0] c, input logic ordy,
                                 input logic fl);
        logic acc, con;
        inValid  = iv;
        inData   = d;
        inCtrl   = c;
        outReady = ordy;
        flush    = fl;
        checkOutput("out_valid", 64'(outValid), 64'(sb.size() > 0));
        checkOutput("in_ready",  64'(inReady),  64'(sb.size() < 2));
        checkOutput("out_data",  64'(outData),  64'(lastOut[CTRL_W +: DATA_W]));
        checkOutput("out_ctrl",  64'(outCtrl),  64'(lastOut[CTRL_W-1:0]));
        checkOutput("stall_cnt", 64'(stallCnt), 64'(modelCnt));
        acc = iv && (sb.size() < 2);
        con = (sb.size() > 0) && ordy;
        if ((sb.size() > 0) && !ordy && (modelCnt != 4'hF)) modelCnt++;
        if (con) void'(sb.pop_front());
        if (fl) begin
            sb.delete();
            lastOut = {{DATA_W{1'b0}}, BUBBLE};
        end else begin
            if (acc) sb.push_back({d, c});
            if (sb.size() > 0) lastOut = sb[0];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Hold reset while the upstream side offers a beat.
        rstN = 1'b0; flush = 1'b0; outReady = 1'b0;
        inValid = 1'b1; inData = 32'hDEADBEEF; inCtrl = 8'h3C;
        modelReset();
        @(negedge clk); @(negedge clk);
        checkOutput("rst out_valid", 64'(outValid), 64'd0);
        checkOutput("rst in_ready",  64'(inReady),  64'd1);
        checkOutput("rst out_data",  64'(outData),  64'd0);
        checkOutput("rst out_ctrl",  64'(outCtrl),  64'(BUBBLE));
        checkOutput("rst stall_cnt", 64'(stallCnt), 64'd0);
        rstN = 1'b1;
        $display("[TB] reset released");

        // The first capture happens on the first edge after reset is released.
        applyStimulus(1'b1, 32'hDEADBEEF, 8'h3C, 1'b0, 1'b0);
        checkOutput("first beat valid", 64'(outValid), 64'd1);
        checkOutput("first beat data",  64'(outData),  64'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 32'(i), 8'(i + 8'h10), 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        checkOutput("stream stall_cnt", 64'(stallCnt), 64'd0);

        // Back-pressure: A and B fill the stage, and C waits upstream.
        applyStimulus(1'b1, 32'h11, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h33, 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h33, 8'h03, 1'b0, 1'b0);
        checkOutput("bp stall after 3", 64'(stallCnt), 64'd3);
        checkOutput("bp in_ready full", 64'(inReady),  64'd0);
        applyStimulus(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0,  8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0,  8'h00, 1'b1, 1'b0);
        checkOutput("bp drained", 64'(sb.size()), 64'd0);

        // Flush while full, with D offered in the same cycle.
        applyStimulus(1'b1, 32'h11, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h44, 8'h04, 1'b0, 1'b1);
        checkOutput("flush out_valid", 64'(outValid), 64'd0);
        checkOutput("flush in_ready",  64'(inReady),  64'd1);
        checkOutput("flush out_data",  64'(outData),  64'd0);
        checkOutput("flush out_ctrl",  64'(outCtrl),  64'(BUBBLE));
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // A flush in the same cycle as a consume delivers the beat, then
        // leaves a bubble.
        applyStimulus(1'b1, 32'h66, 8'h06, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0,  8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0,  8'h00, 1'b1, 1'b0);

        // Drive the narrow stall counter into saturation.
        applyStimulus(1'b1, 32'h55, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        checkOutput("sat stall_cnt", 64'(stallCnt), 64'd15);

        // Fill the stage, then assert reset between clock edges.
        applyStimulus(1'b1, 32'h77, 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  8'h00, 1'b0, 1'b0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("async out_valid", 64'(outValid), 64'd0);
        checkOutput("async in_ready",  64'(inReady),  64'd1);
        checkOutput("async stall_cnt", 64'(stallCnt), 64'd0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
